line_buffer_pingpong: RTL and testbench
=======================================

// Module: line_buffer_pingpong
// PURPOSE
//  Ping-pong video line buffer between the SDRAM serial-read port and the pixel pipeline.
//  Displays line L from one buffer while fetching the next active row into the other.
//  Swaps on the Hblank rising edge; replaces the single-buffer string buffer; generic pixel width/timing.
// PARAMETERS
//  PIX_W       16     pixel/data word width
//  H_ACTIVE    800    active pixels per line = words fetched per row (<=2047)
//  V_ACTIVE    600    active rows per frame (<=2047)
//  V_TOTAL     1056   total lines per frame incl. blanking (V_ACTIVE < V_TOTAL <= 2048)
//  SDRAM_BANK  2'd0   bank driven on data_addr[23:22]
// PORTS
//  clk            in   1      clock
//  rst            in   1      synchronous, active-high reset
//  data           in   PIX_W  SDRAM read word
//  data_valid     in   1      data holds a valid word
//  data_ready     out  1      block accepts a word this cycle
//  serial_access  out  1      serial-read burst request, high for whole fetch
//  data_addr      out  24     {SDRAM_BANK, row[10:0], col[10:0]}
//  v_count        in   11     current display line
//  h_count        in   11     current display pixel
//  hblank         in   1      horizontal blanking
//  pix_color      out  PIX_W  pixel for h_count, registered
//  underrun       out  1      1-cycle pulse: fetch unfinished at a swap edge
//  underrun_cnt   out  16     underrun count (see CONFIGURATION)
// BEHAVIOUR
//  - Two RAMs buf[0..1], H_ACTIVE x PIX_W each; per buffer a tag row (11b) + valid bit.
//  - disp_sel = displayed buffer; fill buffer is always !disp_sel.
//  - Reset: disp_sel=0, both valid=0, pix_color=0, data_ready=0, underrun=0,
//    underrun_cnt=0, col=0, row=0; serial_access=0 during reset; leave reset -> FETCH row 0 into buf1.
//  - FSM IDLE/FETCH. FETCH: serial_access=1, data_ready=1 while col<H_ACTIVE.
//    Word accepted iff data_valid&&data_ready: buf[fill][col]<=data, col++.
//    Accept at col==H_ACTIVE-1: next cycle valid[fill]=1, tag=row, data_ready=0,
//    serial_access=0, state IDLE. data_valid ignored in IDLE.
//  - data_addr combinational from col,row; constant during a stall.
//  - Edge = hblank & !hblank_d (hblank_d reset 0). On edge with L=v_count:
//    D=(L+1) mod V_TOTAL, F=(L+2) mod V_TOTAL (11-bit, explicit wrap).
//    a) D<V_ACTIVE and fill buffer valid with tag D -> disp_sel toggles.
//    b) Then, if F<V_ACTIVE and new fill buffer not (valid && tag==F): invalidate it,
//       row<=F, col<=0, state FETCH (serial_access high next cycle).
//  - Edge while FETCH (underrun): underrun=1 one cycle, partial buffer stays
//    invalid (no swap), fetch aborted; serial_access low >=1 cycle, then restarts per (b).
//  - D<V_ACTIVE but no valid buffer tagged D: no swap, old line repeats; no pulse.
//  - pix_color: 1-cycle latency, <=buf[disp_sel][h_count] if h_count<H_ACTIVE, else 0.
//    Write/read same RAM address same cycle cannot occur (different buffers).
//  - Reset mid-fetch: aborts at once, all state as reset, re-primes row 0.
// CONFIGURATION
//  LB_UNDERRUN_CNT_EN defined: underrun_cnt increments on each underrun pulse,
//    saturates at 16'hFFFF, cleared only by rst.
//  Not defined: underrun_cnt tied to 16'd0, no counter logic; underrun pulse unchanged.
// TESTING
//  1 Reset release, data_valid=1 always -> serial_access=1, addr rows 0 col 0..799,
//    800 words accepted, then serial_access=0, buf1 valid tag 0.
//  2 Edge at v_count=1055 after prime -> disp_sel=1; fetch row 1 starts (addr {bank,11'd1,11'd0});
//    h_count=5 shows row0 word5 one cycle later.
//  3 Edge at v_count=1054 after prime -> no refetch of row 0 (tag hit), serial_access stays 0.
//  4 Stall data_valid=0 so 400/800 words at edge -> underrun 1 cycle, no swap,
//    counter=1 with macro/0 without, fetch restarts col 0.
//  5 Edge at v_count=598 -> fetch row... F=600 suppressed, D=599 swap; v_count 599..1053 no fetch.
//  6 rst at col=300 -> data_ready=0, pix_color=0, then re-prime row 0 from col 0.
//  7 h_count=800..1055 -> pix_color=0; underrun_cnt saturates at 16'hFFFF (forced).

Source files
------------

// File: rtl/line_buffer_pingpong_if.sv
// Ping-pong line buffer bus: SDRAM serial-read side plus display timing/pixel side.
interface line_buffer_pingpong_if #(parameter int PIX_W = 16);
  logic [PIX_W-1:0] data;
  logic             data_valid;
  logic             data_ready;
  logic             serial_access;
  logic [23:0]      data_addr;
  logic [10:0]      v_count;
  logic [10:0]      h_count;
  logic             hblank;
  logic [PIX_W-1:0] pix_color;
  logic             underrun;
  logic [15:0]      underrun_cnt;

  modport master (
    output data, data_valid, v_count, h_count, hblank,
    input  data_ready, serial_access, data_addr, pix_color, underrun, underrun_cnt
  );

  modport slave (
    input  data, data_valid, v_count, h_count, hblank,
    output data_ready, serial_access, data_addr, pix_color, underrun, underrun_cnt
  );
endinterface

// File: rtl/line_buffer_pingpong.sv
// Ping-pong video line buffer: displays one buffer while fetching the next active row into the other.
// Optional underrun counter enabled by defining LB_UNDERRUN_CNT_EN.
module line_buffer_pingpong #(
  parameter int         PIX_W      = 16,
  parameter int         H_ACTIVE   = 800,
  parameter int         V_ACTIVE   = 600,
  parameter int         V_TOTAL    = 1056,
  parameter logic [1:0] SDRAM_BANK = 2'd0
) (
  input logic clk,
  input logic rst,
  line_buffer_pingpong_if.slave bus
);
  localparam int          AW      = $clog2(H_ACTIVE);
  localparam logic [10:0] H_ACT11 = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [11:0] VA12    = 12'(V_ACTIVE);
  localparam logic [11:0] VT12    = 12'(V_TOTAL);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t           state_q, state_d;
  logic             disp_sel;
  logic [1:0]       valid_q;
  logic [10:0]      tag_q [2];
  logic [10:0]      row_q, col_q;
  logic             hblank_d, restart_q, underrun_q;
  logic [PIX_W-1:0] pix_q;
  logic [PIX_W-1:0] mem [2][H_ACTIVE];

  logic        fill, new_fill, edge_det, accept, last, swap, go, underrun_set;
  logic        serial_access, data_ready;
  logic [11:0] l1, l2, d_row, f_row;

  assign fill     = ~disp_sel;
  assign edge_det = bus.hblank & ~hblank_d;
  assign accept   = bus.data_valid & data_ready;
  assign last     = accept && (col_q == H_LAST);

  // Next displayed line and next line to prefetch, wrapped at V_TOTAL.
  assign l1    = {1'b0, bus.v_count} + 12'd1;
  assign l2    = {1'b0, bus.v_count} + 12'd2;
  assign d_row = (l1 >= VT12) ? l1 - VT12 : l1;
  assign f_row = (l2 >= VT12) ? l2 - VT12 : l2;

  assign swap = edge_det && (state_q == IDLE) && (d_row < VA12) &&
                valid_q[fill] && (tag_q[fill] == d_row[10:0]);
  assign new_fill = swap ? disp_sel : fill;
  assign go = edge_det && (f_row < VA12) &&
              !(valid_q[new_fill] && (tag_q[new_fill] == f_row[10:0]));
  assign underrun_set = edge_det && (state_q == FETCH);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // FSM: next state; an aborted fetch always spends one cycle in IDLE before restarting
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (restart_q || go) state_d = FETCH;
      FETCH: if (edge_det || last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    serial_access = (state_q == FETCH) && !rst;
    data_ready    = serial_access && (col_q < H_ACT11);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_sel   <= 1'b0;
      valid_q    <= 2'b00;
      tag_q[0]   <= '0;
      tag_q[1]   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      hblank_d   <= 1'b0;
      restart_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      hblank_d   <= bus.hblank;
      underrun_q <= underrun_set;
      restart_q  <= 1'b0;
      if (edge_det) begin
        if (swap) disp_sel <= ~disp_sel;
        if (go) begin
          valid_q[new_fill] <= 1'b0;
          row_q             <= f_row[10:0];
          col_q             <= '0;
          restart_q         <= (state_q == FETCH);
        end
      end else if (accept) begin
        col_q <= col_q + 11'd1;
        if (last) begin
          valid_q[fill] <= 1'b1;
          tag_q[fill]   <= row_q;
        end
      end
    end
  end

  // Line RAMs: writes only ever target the fill buffer, reads the displayed one.
  always_ff @(posedge clk) begin
    if (accept) mem[fill][col_q[AW-1:0]] <= bus.data;
  end

  always_ff @(posedge clk) begin
    if (rst)                          pix_q <= '0;
    else if (bus.h_count < H_ACT11)   pix_q <= mem[disp_sel][bus.h_count[AW-1:0]];
    else                              pix_q <= '0;
  end

`ifdef LB_UNDERRUN_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst)                                  cnt_q <= '0;
    else if (underrun_set && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign bus.underrun_cnt = cnt_q;
`else
  assign bus.underrun_cnt = 16'd0;
`endif

  assign bus.serial_access = serial_access;
  assign bus.data_ready    = data_ready;
  assign bus.data_addr     = {SDRAM_BANK, row_q, col_q};
  assign bus.pix_color     = pix_q;
  assign bus.underrun      = underrun_q;
endmodule

// File: tb/tb_line_buffer_pingpong.sv
// Randomized bench for line_buffer_pingpong against a line-level reference model.
module tb_line_buffer_pingpong;
  localparam int         PW   = 16;
  localparam int         H    = 16;
  localparam int         VA   = 12;
  localparam int         VT   = 20;
  localparam int         HT   = 28;
  localparam logic [1:0] BANK = 2'd2;
  localparam int         NLN  = 360;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_buffer_pingpong_if #(.PIX_W(PW)) bus ();

  line_buffer_pingpong #(
    .PIX_W(PW), .H_ACTIVE(H), .V_ACTIVE(VA), .V_TOTAL(VT), .SDRAM_BANK(BANK)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which row each buffer holds, what was written where, fetch progress.
  int        m_disp, m_row, m_col, m_cnt;
  int        m_tag [2];
  bit        m_valid [2];
  bit        m_fetch, m_restart, m_under, m_hbd, m_pk;
  logic [PW-1:0] m_pix;
  logic [PW-1:0] m_mem [2][H];
  bit        m_kn [2][H];

  task automatic step(input bit r, input bit dv, input logic [PW-1:0] dat,
                      input int vc, input int hc, input bit hb);
    int fill, d, f, nd, nf;
    bit acc, edg, go;
    if (r) begin
      m_disp = 0; m_valid[0] = 0; m_valid[1] = 0; m_tag[0] = 0; m_tag[1] = 0;
      m_fetch = 1; m_restart = 0; m_row = 0; m_col = 0;
      m_pix = '0; m_pk = 1; m_under = 0; m_cnt = 0; m_hbd = 0;
      return;
    end
    fill = 1 - m_disp;
    acc  = m_fetch && (m_col < H) && dv;
    edg  = hb && !m_hbd;
    if (hc < H) begin m_pix = m_mem[m_disp][hc]; m_pk = m_kn[m_disp][hc]; end
    else begin m_pix = '0; m_pk = 1; end
    if (acc) begin m_mem[fill][m_col] = dat; m_kn[fill][m_col] = 1; end
    m_hbd   = hb;
    m_under = 0;
    if (edg) begin
      d  = (vc + 1) % VT;
      f  = (vc + 2) % VT;
      nd = m_disp;
      if (!m_fetch && d < VA && m_valid[fill] && m_tag[fill] == d) nd = fill;
      m_disp = nd;
      nf = 1 - nd;
      go = (f < VA) && !(m_valid[nf] && m_tag[nf] == f);
      if (m_fetch) begin
        m_under = 1;
        if (m_cnt < 65535) m_cnt++;
        m_fetch = 0;
        if (go) begin m_valid[nf] = 0; m_row = f; m_col = 0; m_restart = 1; end
      end else if (go) begin
        m_valid[nf] = 0; m_row = f; m_col = 0; m_fetch = 1;
      end
    end else if (m_restart) begin
      m_restart = 0; m_fetch = 1;
    end else if (acc) begin
      m_col++;
      if (m_col == H) begin m_valid[fill] = 1; m_tag[fill] = m_row; m_fetch = 0; end
    end
  endtask

  task automatic check_outputs();
    bit   exp_sa, exp_rdy;
    logic [23:0] exp_addr;
    int   exp_cnt;
    exp_sa  = m_fetch && !rst;
    exp_rdy = exp_sa && (m_col < H);
`ifdef LB_UNDERRUN_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    chk("serial_access", 32'(bus.serial_access), 32'(exp_sa));
    chk("data_ready", 32'(bus.data_ready), 32'(exp_rdy));
    if (exp_sa) begin
      exp_addr = {BANK, 11'(m_row), 11'(m_col)};
      chk("data_addr", 32'(bus.data_addr), 32'(exp_addr));
    end
    if (m_pk) chk("pix_color", 32'(bus.pix_color), 32'(m_pix));
    chk("underrun", 32'(bus.underrun), 32'(m_under));
    chk("underrun_cnt", 32'(bus.underrun_cnt), 32'(exp_cnt));
  endtask

  task automatic drive(input bit r, input bit dv, input logic [PW-1:0] dat,
                       input int vc, input int hc, input bit hb);
    rst            = r;
    bus.data_valid = dv;
    bus.data       = dat;
    bus.v_count    = 11'(vc);
    bus.h_count    = 11'(hc);
    bus.hblank     = hb;
  endtask

  initial begin
    int hc, vc, ln, rst_left, rst_hc, mode;
    bit dv, hb;
    logic [PW-1:0] dat;
    hc = 0; vc = 0; ln = 0; rst_left = 3; rst_hc = 20;
    drive(1'b1, 1'b0, '0, vc, hc, 1'b0);
    step(1'b1, 1'b0, '0, vc, hc, 1'b0);
    rst_left--;
    while (ln < NLN) begin
      @(negedge clk);
      check_outputs();
      hc = (hc + 1) % HT;
      if (hc == 0) begin
        vc = (vc + 1) % VT;
        ln++;
        rst_hc = 16 + int'($urandom_range(0, 10));
      end
      // Periodic mid-line resets land inside or just before a fetch.
      if ((ln % 90) == 45 && hc == rst_hc) rst_left = 2;
      mode = (ln / 40) % 3;
      case (mode)
        0:       dv = 1'b1;
        1:       dv = ($urandom_range(0, 1) == 1);
        default: dv = ($urandom_range(0, 7) != 0);
      endcase
      hb  = (hc >= H);
      dat = PW'($urandom);
      drive(rst_left > 0, dv, dat, vc, hc, hb);
      step(rst_left > 0, dv, dat, vc, hc, hb);
      if (rst_left > 0) rst_left--;
    end
    @(negedge clk);
    check_outputs();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
